// File: rtl/act_queue_pkg.sv
// Shared types and constants for the activation queue.
// The optional mark/rewind replay logic is built when ACT_QUEUE_REPLAY_EN is defined.
package act_queue_pkg;

    localparam int DEFAULT_DEPTH = 32;
    localparam int DEFAULT_WIDTH = 24;

    typedef enum logic {
        IDLE   = 1'b0,
        MARKED = 1'b1
    } replay_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/act_queue_storage.sv
// Two-port entry storage: synchronous write, registered read (old data on same-address write).
module act_queue_storage
    import act_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = clog2(DEFAULT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Entry array write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/act_queue_ctrl.sv
// Pointer-managed activation FIFO with valid/ready on both sides and synchronous flush.
// Defining ACT_QUEUE_REPLAY_EN adds mark / rewind / release_mark replay of popped entries.
module act_queue_ctrl
    import act_queue_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
`ifdef ACT_QUEUE_REPLAY_EN
    ,
    input  logic             mark,
    input  logic             rewind,
    input  logic             release_mark
`endif
);

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [AW:0]      count_r, count_nxt_s, avail_s, avail_nxt_s;
    logic             full_r, empty_r;
    logic             push_s, pop_s, wr_en_s;
    logic             byp_valid_r;
    logic [WIDTH-1:0] byp_data_r, rd_data_s;

`ifdef ACT_QUEUE_REPLAY_EN
    // avail counts readable entries; count also includes entries retained for rewind
    logic [AW:0]      avail_r;
    logic [AW-1:0]    mark_ptr_r, mark_ptr_nxt_s;
    replay_state_e    state_r, state_nxt_s;
    assign avail_s = avail_r;
`else
    assign avail_s = count_r;
`endif

    // Handshakes, pointer and counter next-state
    always_comb begin
        push_s       = in_valid && !full_r;
        pop_s        = out_ready && !empty_r;
        wr_en_s      = push_s && !flush;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        avail_nxt_s  = avail_s;
`ifdef ACT_QUEUE_REPLAY_EN
        mark_ptr_nxt_s = mark_ptr_r;
        state_nxt_s    = state_r;
`endif
        if (flush) begin
            wr_ptr_nxt_s = {AW{1'b0}};
            rd_ptr_nxt_s = {AW{1'b0}};
            count_nxt_s  = {(AW + 1){1'b0}};
            avail_nxt_s  = {(AW + 1){1'b0}};
`ifdef ACT_QUEUE_REPLAY_EN
            mark_ptr_nxt_s = {AW{1'b0}};
            state_nxt_s    = IDLE;
`endif
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                count_nxt_s  = count_r + CNT_ONE;
                avail_nxt_s  = avail_s + CNT_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
`ifdef ACT_QUEUE_REPLAY_EN
            if (rewind && (state_r == MARKED)) begin
                rd_ptr_nxt_s = mark_ptr_r;
                avail_nxt_s  = count_nxt_s;
            end else begin
                if (pop_s) begin
                    rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                    avail_nxt_s  = avail_nxt_s - CNT_ONE;
                    count_nxt_s  = (state_r == MARKED) ? count_nxt_s : count_nxt_s - CNT_ONE;
                end else begin
                    rd_ptr_nxt_s = rd_ptr_r;
                end
                // A new mark or a release frees everything behind the head
                if (mark) begin
                    mark_ptr_nxt_s = rd_ptr_nxt_s;
                    state_nxt_s    = MARKED;
                    count_nxt_s    = avail_nxt_s;
                end else if (release_mark) begin
                    state_nxt_s = IDLE;
                    count_nxt_s = avail_nxt_s;
                end else begin
                    state_nxt_s = state_r;
                end
            end
`else
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                count_nxt_s  = count_nxt_s - CNT_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            avail_nxt_s = count_nxt_s;
`endif
        end
    end

    // State registers; status flags are registered from the next-state counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {(AW + 1){1'b0}};
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            byp_valid_r <= 1'b0;
            byp_data_r  <= {WIDTH{1'b0}};
`ifdef ACT_QUEUE_REPLAY_EN
            avail_r     <= {(AW + 1){1'b0}};
            mark_ptr_r  <= {AW{1'b0}};
            state_r     <= IDLE;
`endif
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            full_r      <= (count_nxt_s == FULL_CNT);
            empty_r     <= (avail_nxt_s == {(AW + 1){1'b0}});
            // Storage returns old data when the fetched address is written in the same cycle
            byp_valid_r <= wr_en_s && (wr_ptr_r == rd_ptr_nxt_s);
            byp_data_r  <= in_data;
`ifdef ACT_QUEUE_REPLAY_EN
            avail_r     <= avail_nxt_s;
            mark_ptr_r  <= mark_ptr_nxt_s;
            state_r     <= state_nxt_s;
`endif
        end
    end

    act_queue_storage #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (in_data),
        .rd_en   (1'b1),
        .rd_addr (rd_ptr_nxt_s),
        .rd_data (rd_data_s)
    );

    assign in_ready  = !full_r;
    assign out_valid = !empty_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign count     = count_r;
    assign out_data  = empty_r ? {WIDTH{1'b0}} : (byp_valid_r ? byp_data_r : rd_data_s);

endmodule

// File: tb/tb_act_queue_ctrl.sv
// Self-checking bench for act_queue_ctrl: vector table, directed corner sequences and
// randomized traffic against a queue-based model (replay cases when ACT_QUEUE_REPLAY_EN is set).
module tb_act_queue_ctrl;
    import act_queue_pkg::*;

    localparam int DEPTH = 32;
    localparam int WIDTH = 24;
    localparam int AW    = clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, out_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_ready, out_valid, full, empty;
    logic [WIDTH-1:0] out_data;
    logic [AW:0]      count;
    logic             mk = 1'b0, rw = 1'b0, rl = 1'b0;

    int total = 0;
    int bad   = 0;

    // Model: held entries in order, oldest first; the first hidx are retained for rewind
    logic [WIDTH-1:0] held[$];
    int               hidx   = 0;
    bit               marked = 1'b0;

    typedef struct {
        logic             fl;
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             ev;
        logic [WIDTH-1:0] ed;
        logic [AW:0]      ec;
        logic             ef;
        logic             ee;
    } vec_t;

    vec_t vecs[9];

    act_queue_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef ACT_QUEUE_REPLAY_EN
        ,
        .mark         (mk),
        .rewind       (rw),
        .release_mark (rl)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drop_retained();
        repeat (hidx) void'(held.pop_front());
        hidx = 0;
    endtask

    task automatic model_step();
        bit push, pop;
        int avail;
        avail = held.size() - hidx;
        push  = in_valid && (held.size() < DEPTH);
        pop   = out_ready && (avail > 0);
        if (flush) begin
            held.delete();
            hidx   = 0;
            marked = 1'b0;
        end else begin
            if (push) held.push_back(in_data);
            if (rw && marked) begin
                hidx = 0;
            end else begin
                if (pop) begin
                    if (marked) hidx++;
                    else void'(held.pop_front());
                end
                if (mk) begin
                    drop_retained();
                    marked = 1'b1;
                end else if (rl) begin
                    drop_retained();
                    marked = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        if (rst) begin
            held.delete();
            hidx   = 0;
            marked = 1'b0;
        end else begin
            model_step();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name);
        int avail;
        logic [31:0] ed;
        avail = held.size() - hidx;
        ed    = (avail > 0) ? 32'(held[hidx]) : 32'd0;
        chk({name, "/in_ready"},  32'(in_ready),  32'(held.size() < DEPTH));
        chk({name, "/out_valid"}, 32'(out_valid), 32'(avail > 0));
        chk({name, "/out_data"},  32'(out_data),  ed);
        chk({name, "/count"},     32'(count),     held.size());
        chk({name, "/full"},      32'(full),      32'(held.size() == DEPTH));
        chk({name, "/empty"},     32'(empty),     32'(avail == 0));
    endtask

    task automatic set_in(input logic fl, input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 24'h0, 1'b0);

        // Reset values
        cycle();
        cycle();
        chk("rst/in_ready", 32'(in_ready), 32'd1);
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/out_data", 32'(out_data), 32'd0);
        chk("rst/count", 32'(count), 32'd0);
        chk("rst/full", 32'(full), 32'd0);
        chk("rst/empty", 32'(empty), 32'd1);
        rst = 1'b0;

        // Hand-derived vectors from empty: latency, simultaneous push/pop, bypass, flush
        vecs[0] = '{1'b0, 1'b1, 24'hA5A5A5, 1'b0, 1'b1, 24'hA5A5A5, 6'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 24'h111111, 1'b0, 1'b1, 24'hA5A5A5, 6'd2, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 24'h222222, 1'b1, 1'b1, 24'h111111, 6'd2, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'h222222, 6'd1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h000000, 6'd0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 24'h000000, 6'd0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 24'h333333, 1'b1, 1'b1, 24'h333333, 6'd1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 24'h444444, 1'b1, 1'b1, 24'h444444, 6'd1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 24'h555555, 1'b1, 1'b0, 24'h000000, 6'd0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            cycle();
            chk($sformatf("vec%0d/out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d/out_data", i), 32'(out_data), 32'(vecs[i].ed));
            chk($sformatf("vec%0d/count", i), 32'(count), 32'(vecs[i].ec));
            chk($sformatf("vec%0d/full", i), 32'(full), 32'(vecs[i].ef));
            chk($sformatf("vec%0d/empty", i), 32'(empty), 32'(vecs[i].ee));
        end

        // Fill to DEPTH, reject a further push, full blocks push even with a pop
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b0, 1'b1, 24'(i), 1'b0);
            cycle();
        end
        chk("fill/full", 32'(full), 32'd1);
        chk("fill/in_ready", 32'(in_ready), 32'd0);
        chk("fill/count", 32'(count), 32'd32);
        set_in(1'b0, 1'b1, 24'h000099, 1'b0);
        cycle();
        chk("fill/extra_count", 32'(count), 32'd32);
        set_in(1'b0, 1'b1, 24'h000999, 1'b1);
        cycle();
        chk("fill/pushpop_count", 32'(count), 32'd31);
        chk("fill/pushpop_head", 32'(out_data), 32'd1);
        chk("fill/pushpop_ready", 32'(in_ready), 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            chk($sformatf("drain%0d/data", i), 32'(out_data), i);
            set_in(1'b0, 1'b0, 24'h0, 1'b1);
            cycle();
        end
        chk("drain/empty", 32'(empty), 32'd1);
        check_all("drain");

        // Steady state at count 5 across pointer wraps
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, 24'(24'h100 + i), 1'b0);
            cycle();
        end
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("steady%0d/data", i), 32'(out_data), 32'h100 + i);
            set_in(1'b0, 1'b1, 24'(24'h105 + i), 1'b1);
            cycle();
            chk($sformatf("steady%0d/count", i), 32'(count), 32'd5);
        end
        check_all("steady");

        // Flush with push and pop at count 7
        set_in(1'b1, 1'b0, 24'h0, 1'b0);
        cycle();
        for (int i = 0; i < 7; i++) begin
            set_in(1'b0, 1'b1, 24'(24'h700 + i), 1'b0);
            cycle();
        end
        chk("pre_flush/count", 32'(count), 32'd7);
        set_in(1'b1, 1'b1, 24'hABCDEF, 1'b1);
        cycle();
        chk("flush/count", 32'(count), 32'd0);
        chk("flush/empty", 32'(empty), 32'd1);
        chk("flush/out_valid", 32'(out_valid), 32'd0);
        chk("flush/out_data", 32'(out_data), 32'd0);

        // Reset mid-operation discards contents
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 24'(24'h900 + i), 1'b0);
            cycle();
        end
        rst = 1'b1;
        set_in(1'b0, 1'b1, 24'h123456, 1'b1);
        cycle();
        rst = 1'b0;
        chk("midrst/count", 32'(count), 32'd0);
        chk("midrst/empty", 32'(empty), 32'd1);
        chk("midrst/in_ready", 32'(in_ready), 32'd1);

`ifdef ACT_QUEUE_REPLAY_EN
        // Mark, pop 1..4, rewind, pop again, release
        set_in(1'b0, 1'b0, 24'h0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b0, 1'b1, 24'(i), 1'b0);
            cycle();
        end
        set_in(1'b0, 1'b0, 24'h0, 1'b0);
        mk = 1'b1;
        cycle();
        mk = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("rp_pop%0d", i), 32'(out_data), i);
            set_in(1'b0, 1'b0, 24'h0, 1'b1);
            cycle();
        end
        chk("rp/retained_count", 32'(count), 32'd4);
        chk("rp/retained_empty", 32'(empty), 32'd1);
        set_in(1'b0, 1'b0, 24'h0, 1'b0);
        rw = 1'b1;
        cycle();
        rw = 1'b0;
        chk("rp/rewind_data", 32'(out_data), 32'd1);
        chk("rp/rewind_count", 32'(count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("rp_repop%0d", i), 32'(out_data), i);
            set_in(1'b0, 1'b0, 24'h0, 1'b1);
            cycle();
        end
        set_in(1'b0, 1'b0, 24'h0, 1'b0);
        rl = 1'b1;
        cycle();
        rl = 1'b0;
        chk("rp/release_count", 32'(count), 32'd0);

        // Rewind with no mark is ignored; rewind with a pop ignores the pop
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 24'(24'hB0 + i), 1'b0);
            cycle();
        end
        set_in(1'b0, 1'b0, 24'h0, 1'b0);
        rw = 1'b1;
        cycle();
        rw = 1'b0;
        chk("rp/nomark_count", 32'(count), 32'd3);
        chk("rp/nomark_data", 32'(out_data), 32'hB0);
        mk = 1'b1;
        cycle();
        mk = 1'b0;
        set_in(1'b0, 1'b0, 24'h0, 1'b1);
        cycle();
        chk("rp/popped_data", 32'(out_data), 32'hB1);
        rw = 1'b1;
        cycle();
        rw = 1'b0;
        set_in(1'b0, 1'b0, 24'h0, 1'b0);
        chk("rp/rwpop_data", 32'(out_data), 32'hB0);
        chk("rp/rwpop_count", 32'(count), 32'd3);
        check_all("rp/rwpop");
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 24'($urandom), ($urandom_range(0, 2) != 0));
`ifdef ACT_QUEUE_REPLAY_EN
            mk = ($urandom_range(0, 15) == 0);
            rw = ($urandom_range(0, 15) == 0);
            rl = ($urandom_range(0, 23) == 0);
`endif
            cycle();
            check_all($sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
